// File: rtl/cal_pkg.sv
`default_nettype none
// ============================================================================
// Module : cal_pkg
// Desc   : Shared types and helpers for the offset-calibration sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package cal_pkg;

    localparam int DEFAULT_W = 24;
    localparam int MAX_CH    = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_ARM    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_NEXT   = 3'd4,
        ST_FIN    = 3'd5
    } cal_state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } bit_sel_t;

    // Lowest set bit of mask at or above index 'from'.
    function automatic bit_sel_t next_set_bit(input logic [MAX_CH-1:0] mask,
                                              input logic [4:0]        from);
        bit_sel_t res;
        res.found = 1'b0;
        res.idx   = 4'd0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i] && (5'(i) >= from)) begin
                res.found = 1'b1;
                res.idx   = 4'(i);
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cal_offset_seq_if.sv
`default_nettype none
// ============================================================================
// Module : cal_offset_seq_if
// Desc   : Handshake bus between the calibration sequencer and the averager.
// Rev    : 1.0  initial release
// ============================================================================
interface cal_offset_seq_if #(
    parameter int W = 24
) ();
    logic         avg_start;
    logic [W-1:0] avg_din;
    logic         avg_din_valid;
    logic         avg_busy;
    logic         avg_done;
    logic [W-1:0] avg_offset;

    modport master (
        output avg_start, avg_din, avg_din_valid,
        input  avg_busy, avg_done, avg_offset
    );

    modport slave (
        input  avg_start, avg_din, avg_din_valid,
        output avg_busy, avg_done, avg_offset
    );
endinterface
`default_nettype wire

// File: rtl/cal_ch_mux.sv
`default_nettype none
// ============================================================================
// Module : cal_ch_mux
// Desc   : NCH:1 sample/strobe selector, forced to zero when not enabled.
// Rev    : 1.0  initial release
// ============================================================================
module cal_ch_mux #(
    parameter int W   = 24,
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input  wire [NCH*W-1:0] i_din,
    input  wire [NCH-1:0]   i_din_valid,
    input  wire [CW-1:0]    i_sel,
    input  wire             i_en,
    output logic [W-1:0]    o_dout,
    output logic            o_dout_valid
);

    always_comb begin
        o_dout       = '0;
        o_dout_valid = 1'b0;
        if (i_en) begin
            o_dout       = i_din[i_sel*W +: W];
            o_dout_valid = i_din_valid[i_sel];
        end
    end

endmodule
`default_nettype wire

// File: rtl/cal_offset_seq.sv
`default_nettype none
// ============================================================================
// Module : cal_offset_seq
// Desc   : Sweeps enabled channels through settle / average / store, filling
//          a per-channel offset bank.
// Rev    : 1.0  initial release
// ============================================================================
module cal_offset_seq
    import cal_pkg::*;
#(
    parameter int W              = DEFAULT_W,
    parameter int NCH            = 4,
    parameter int SETTLE_SAMPLES = 16,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CW             = $clog2(NCH)
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire              cal_req,
    input  wire              abort,
    input  wire  [NCH-1:0]   ch_mask,
    input  wire  [NCH*W-1:0] din,
    input  wire  [NCH-1:0]   din_valid,
    cal_offset_seq_if.master avg,
    output logic             cal_mode,
    output logic [CW-1:0]    cur_ch,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             err_sticky,
    output logic [NCH*W-1:0] ofs_bank,
    output logic [NCH-1:0]   ofs_valid
);

    localparam int c_cnt_max = (SETTLE_SAMPLES > TIMEOUT_CYCLES) ? SETTLE_SAMPLES : TIMEOUT_CYCLES;
    localparam int c_cntw    = $clog2(c_cnt_max + 1);
    localparam logic [c_cntw-1:0] c_settle_load  = c_cntw'(SETTLE_SAMPLES - 1);
    localparam logic [c_cntw-1:0] c_timeout_load = c_cntw'(TIMEOUT_CYCLES - 1);

    cal_state_t        r_state;
    logic [NCH-1:0]    r_mask;
    logic [CW-1:0]     r_cur_ch;
    logic [c_cntw-1:0] r_cnt;
    logic              r_avg_start;
    logic              r_cal_mode;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_err_sticky;
    logic [NCH*W-1:0]  r_ofs_bank;
    logic [NCH-1:0]    r_ofs_valid;

    logic              w_in_wait;
    logic              w_cur_valid;
    logic [W-1:0]      w_avg_din;
    logic              w_avg_din_valid;
    bit_sel_t          w_first;
    bit_sel_t          w_next;

    assign w_in_wait   = (r_state == ST_WAIT);
    assign w_cur_valid = din_valid[r_cur_ch];
    assign w_first     = next_set_bit(MAX_CH'(ch_mask), 5'd0);
    assign w_next      = next_set_bit(MAX_CH'(r_mask), 5'(r_cur_ch) + 5'd1);

    cal_ch_mux #(
        .W   (W),
        .NCH (NCH),
        .CW  (CW)
    ) u_ch_mux (
        .i_din        (din),
        .i_din_valid  (din_valid),
        .i_sel        (r_cur_ch),
        .i_en         (w_in_wait),
        .o_dout       (w_avg_din),
        .o_dout_valid (w_avg_din_valid)
    );

    // One down-counter serves both settle sample counting and the done timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_mask       <= '0;
            r_cur_ch     <= '0;
            r_cnt        <= '0;
            r_avg_start  <= 1'b0;
            r_cal_mode   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
            r_ofs_bank   <= '0;
            r_ofs_valid  <= '0;
        end else begin
            r_avg_start <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            if (abort && (r_state != ST_IDLE)) begin
                r_state    <= ST_IDLE;
                r_busy     <= 1'b0;
                r_cal_mode <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (cal_req) begin
                            if (ch_mask != '0) begin
                                r_mask       <= ch_mask;
                                r_cur_ch     <= CW'(w_first.idx);
                                r_ofs_valid  <= r_ofs_valid & ~ch_mask;
                                r_err_sticky <= 1'b0;
                                r_busy       <= 1'b1;
                                r_cal_mode   <= 1'b1;
                                r_cnt        <= c_settle_load;
                                r_state      <= ST_SETTLE;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    ST_SETTLE: begin
                        if (w_cur_valid) begin
                            if (r_cnt == '0) r_state <= ST_ARM;
                            else             r_cnt   <= r_cnt - 1'b1;
                        end
                    end
                    ST_ARM: begin
                        if (!avg.avg_busy) begin
                            r_avg_start <= 1'b1;
                            r_cnt       <= c_timeout_load;
                            r_state     <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (avg.avg_done) begin
                            r_ofs_bank[r_cur_ch*W +: W] <= avg.avg_offset;
                            r_ofs_valid[r_cur_ch]       <= 1'b1;
                            r_state                     <= ST_NEXT;
                        end else if (r_cnt == '0) begin
                            r_err        <= 1'b1;
                            r_err_sticky <= 1'b1;
                            r_state      <= ST_NEXT;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    ST_NEXT: begin
                        if (w_next.found) begin
                            r_cur_ch <= CW'(w_next.idx);
                            r_cnt    <= c_settle_load;
                            r_state  <= ST_SETTLE;
                        end else begin
                            r_busy     <= 1'b0;
                            r_cal_mode <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= ST_FIN;
                        end
                    end
                    ST_FIN:  r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign avg.avg_start     = r_avg_start;
    assign avg.avg_din       = w_avg_din;
    assign avg.avg_din_valid = w_avg_din_valid;
    assign cal_mode          = r_cal_mode;
    assign cur_ch            = r_cur_ch;
    assign busy              = r_busy;
    assign done              = r_done;
    assign err               = r_err;
    assign err_sticky        = r_err_sticky;
    assign ofs_bank          = r_ofs_bank;
    assign ofs_valid         = r_ofs_valid;

endmodule
`default_nettype wire

// File: tb/tb_cal_offset_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_cal_offset_seq
// Desc   : Directed bench for cal_offset_seq with a 16-sample averager model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cal_offset_seq;

    localparam int W   = 24;
    localparam int NCH = 4;
    localparam int CW  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cal_req;
    logic             abort;
    logic [NCH-1:0]   ch_mask;
    logic [NCH*W-1:0] din;
    logic [NCH-1:0]   din_valid;
    logic [NCH-1:0]   valid_en;
    logic             cal_mode, busy, done, err, err_sticky;
    logic [CW-1:0]    cur_ch;
    logic [NCH*W-1:0] ofs_bank;
    logic [NCH-1:0]   ofs_valid;
    logic             tog = 1'b0;
    int               ch_val [NCH];

    int n_checks = 0;
    int n_errors = 0;

    cal_offset_seq_if #(.W(W)) aif ();

    cal_offset_seq #(
        .W(W), .NCH(NCH), .SETTLE_SAMPLES(4), .TIMEOUT_CYCLES(200), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cal_req(cal_req), .abort(abort),
        .ch_mask(ch_mask), .din(din), .din_valid(din_valid), .avg(aif),
        .cal_mode(cal_mode), .cur_ch(cur_ch), .busy(busy), .done(done),
        .err(err), .err_sticky(err_sticky), .ofs_bank(ofs_bank), .ofs_valid(ofs_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tog <= ~tog;
    assign din_valid = {NCH{tog}} & valid_en;

    always_comb begin
        din = '0;
        for (int k = 0; k < NCH; k++) din[k*W +: W] = ch_val[k][W-1:0];
    end

    // Averager model: 16 samples after start, result = sum >>> 4.
    logic                m_busy, m_done, avg_clr;
    logic [W-1:0]        m_ofs;
    logic signed [W+3:0] m_acc, m_ext, m_sum;
    int                  m_cnt;
    assign m_ext = {{4{aif.avg_din[W-1]}}, aif.avg_din};
    assign m_sum = m_acc + m_ext;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_ofs <= '0; m_acc <= '0; m_cnt <= 0;
        end else begin
            m_done <= 1'b0;
            if (avg_clr) begin
                m_busy <= 1'b0;
            end else if (aif.avg_start) begin
                m_busy <= 1'b1; m_acc <= '0; m_cnt <= 0;
            end else if (m_busy && aif.avg_din_valid) begin
                if (m_cnt == 15) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_ofs  <= m_sum[W+3:4];
                end else begin
                    m_acc <= m_sum;
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    assign aif.avg_busy   = m_busy;
    assign aif.avg_done   = m_done;
    assign aif.avg_offset = m_ofs;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NCH*W-1:0] pack_bank(input int v0, input int v1, input int v2, input int v3);
        return {v3[W-1:0], v2[W-1:0], v1[W-1:0], v0[W-1:0]};
    endfunction

    int n_starts, done_gap, start_ch [8];
    bit mode_ok;

    task automatic pulse_req(input logic [NCH-1:0] mask);
        ch_mask = mask; cal_req = 1'b1;
        @(negedge clk);
        cal_req = 1'b0;
    endtask

    task automatic wait_start(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (aif.avg_start) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    // Runs a sweep to completion; optionally re-requests with a new mask mid-sweep.
    task automatic run_sweep(input logic [NCH-1:0] mask, input bit poke, input int budget);
        int last_mdone;
        bit got_done;
        logic [W-1:0] exp_din;
        n_starts = 0; mode_ok = 1'b1; last_mdone = -100; done_gap = -1; got_done = 1'b0;
        pulse_req(mask);
        for (int i = 0; i < budget && !got_done; i++) begin
            if (aif.avg_start) begin
                exp_din = ch_val[cur_ch][W-1:0];
                check("avg_din_sel", aif.avg_din, exp_din);
                if (n_starts < 8) start_ch[n_starts] = int'(cur_ch);
                n_starts++;
            end
            if (m_done) last_mdone = i;
            if (done) begin
                got_done = 1'b1;
                done_gap = i - last_mdone;
            end else if (busy !== 1'b1 || cal_mode !== 1'b1) begin
                mode_ok = 1'b0;
            end
            if (poke && n_starts == 1) begin cal_req = 1'b1; ch_mask = '1; end
            else cal_req = 1'b0;
            @(negedge clk);
        end
        cal_req = 1'b0;
        check("sweep_done_seen", got_done, 1);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int err_at;
        int n_seen;
        rst_n = 1'b0; cal_req = 1'b0; abort = 1'b0; ch_mask = '0; avg_clr = 1'b0;
        valid_en = '1;
        for (int k = 0; k < NCH; k++) ch_val[k] = 100 * k - 50;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_cal_mode", cal_mode, 0);
        check("rst_done_err", {done, err, err_sticky}, 0);
        check("rst_cur_ch", cur_ch, 0);
        check("rst_ofs_valid", ofs_valid, 0);
        check("rst_ofs_bank", ofs_bank, 0);
        check("idle_avg_start", aif.avg_start, 0);
        @(negedge clk);
        check("idle_avg_din_valid", {aif.avg_din_valid, aif.avg_din}, 0);

        // Full sweep
        run_sweep(4'b1111, 1'b0, 2000);
        check("full_nstarts", n_starts, 4);
        check("full_order", {start_ch[0][3:0], start_ch[1][3:0], start_ch[2][3:0], start_ch[3][3:0]}, 16'h0123);
        check("full_bank", ofs_bank, pack_bank(-50, 50, 150, 250));
        check("full_valid", ofs_valid, 4'b1111);
        check("full_mode_high", mode_ok, 1);
        check("full_done_gap", done_gap, 2);
        check("full_err_sticky", err_sticky, 0);
        check("full_busy_off", {busy, cal_mode}, 0);

        // Sparse mask with mid-sweep cal_req / mask change
        for (int k = 0; k < NCH; k++) ch_val[k] = 1000 + k;
        run_sweep(4'b1010, 1'b1, 2000);
        check("sparse_nstarts", n_starts, 2);
        check("sparse_order", {start_ch[0][3:0], start_ch[1][3:0]}, 8'h13);
        check("sparse_bank", ofs_bank, pack_bank(-50, 1001, 150, 1003));
        check("sparse_valid", ofs_valid, 4'b1111);

        // Timeout on channel 2
        pulse_req(4'b0100);
        wait_start(200, ok);
        check("to_start_seen", ok, 1);
        valid_en[2] = 1'b0;
        check("to_cur_ch", cur_ch, 2);
        err_at = -1;
        for (int i = 1; i <= 260; i++) begin
            @(negedge clk);
            if (err) begin err_at = i; break; end
        end
        check("to_err_cycle", err_at, 200);
        check("to_err_sticky", err_sticky, 1);
        check("to_valid", ofs_valid, 4'b1011);
        @(negedge clk);
        check("to_done_follows", {done, err}, 2'b10);
        check("to_bank_kept", ofs_bank, pack_bank(-50, 1001, 150, 1003));
        avg_clr = 1'b1; @(negedge clk); avg_clr = 1'b0;
        valid_en = '1;
        @(negedge clk);

        // Abort in channel-1 WAIT, then immediate new request
        for (int k = 0; k < NCH; k++) ch_val[k] = 100 * k - 50;
        pulse_req(4'b0011);
        wait_start(200, ok);
        @(negedge clk);
        wait_start(200, ok);
        check("ab_ch1_start", {ok, cur_ch}, {1'b1, 2'd1});
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_idle", {busy, cal_mode, done, err}, 0);
        check("ab_valid", ofs_valid, 4'b1001);
        check("ab_bank0", ofs_bank[W-1:0], 24'hFFFFCE);
        pulse_req(4'b0011);
        check("ab_restart_busy", {busy, ofs_valid}, {1'b1, 4'b1000});
        n_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (aif.avg_start) n_seen++;
            @(negedge clk);
        end
        check("ab_arm_holds", n_seen, 0);
        avg_clr = 1'b1; @(negedge clk); avg_clr = 1'b0;
        wait_done(1000, ok);
        check("ab_done_seen", ok, 1);
        check("ab_bank", ofs_bank, pack_bank(-50, 50, 150, 1003));
        check("ab_valid_final", ofs_valid, 4'b1011);
        check("ab_err_sticky", err_sticky, 0);
        repeat (2) @(negedge clk);

        // Empty mask
        pulse_req(4'b0000);
        check("m0_done", {done, busy}, 2'b10);
        @(negedge clk);
        check("m0_after", {done, busy, cal_mode}, 0);
        check("m0_valid_kept", ofs_valid, 4'b1011);

        // Asynchronous reset mid-WAIT, then a clean sweep
        pulse_req(4'b0001);
        wait_start(200, ok);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("ar_busy_mode", {busy, cal_mode, err_sticky, cur_ch}, 0);
        check("ar_bank", ofs_bank, 0);
        check("ar_valid", ofs_valid, 0);
        check("ar_avg", {aif.avg_start, aif.avg_din_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sweep(4'b1111, 1'b0, 2000);
        check("ar_sweep_bank", ofs_bank, pack_bank(-50, 50, 150, 250));
        check("ar_sweep_valid", ofs_valid, 4'b1111);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
